ccff_chain_loader: RTL and testbench
====================================

Name: ccff_chain_loader

Overview:
- Bit-serial configuration-chain driver sitting directly upstream of a logic tile's ccff_head input. It feeds the frac_logic configuration chain: frac_lut4 SRAM, then the output-mux mem, then the cin-mux mem.
- Accepts parallel bitstream words over a valid/ready handshake, serialises them MSB-first onto ccff_head and asserts a shift enable for exactly CHAIN_LEN cycles.
- Reports completion and starvation. Optionally signatures the bits leaving ccff_tail.

Parameters:
- WORD_W, 8, bitstream word width in bits (>=2).
- CHAIN_LEN, 20, number of configuration flops in the downstream chain (>=1).
- CNT_W, $clog2(CHAIN_LEN+1), width of the bit counter (derived; not overridden).

Ports:
- prog_clk  input  1  configuration clock; all state on rising edge.
- prog_reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin a chain load.
- abort  input  1  synchronous cancel of an in-progress load.
- word_data  input  WORD_W  bitstream word.
- word_valid  input  1  word_data valid.
- word_ready  output  1  loader can accept word_data this cycle.
- ccff_head  output  1  serial configuration bit to the chain.
- ccff_shift_en  output  1  chain clock-enable; the chain advances only on cycles where this is 1.
- ccff_tail  input  1  serial bit returning from the chain end.
- busy  output  1  high from accepted start until the cycle after the last bit.
- done  output  1  one-cycle pulse on successful completion.
- underrun  output  1  sticky flag: shifting stalled for lack of data during the current/last load.

Behaviour:
- Reset (prog_reset=0): state IDLE. word_ready, ccff_head, ccff_shift_en, busy, done and underrun are all 0. bit counter = 0 and both word buffers are empty. Any partially loaded chain contents are left as-is.
- Storage: shift register SR (WORD_W bits plus a remaining-bit count) and one holding register HR (WORD_W plus a full flag). word_ready = busy & ~HR.full & ~abort.
- Handshake: a word transfers when word_valid & word_ready. It goes into SR if SR is empty or empties this cycle; otherwise it goes into HR. HR drains to SR on the cycle SR empties. Words offered while in IDLE are not accepted.
- FSM:
  - IDLE: start -> LOAD; clears bit counter and underrun; busy goes 1.
  - LOAD: waits for SR non-empty -> SHIFT.
  - SHIFT: each cycle with SR non-empty, ccff_head <= SR MSB, ccff_shift_en <= 1, SR shifts left, bit counter +1. Both outputs are registered and change together.
  - SHIFT stall: if SR is empty while bit counter < CHAIN_LEN, ccff_shift_en <= 0, ccff_head holds its last value, and underrun <= 1. Shifting resumes seamlessly when data arrives.
  - SHIFT exit: when bit counter reaches CHAIN_LEN, go to DONE. Remaining SR/HR bits are discarded; if CHAIN_LEN % WORD_W != 0, the final word's low-order bits are dropped.
  - DONE: done=1 for one cycle, busy=0, ccff_shift_en=0, word_ready=0 -> IDLE.
- Latency: the first ccff_shift_en=1 appears 1 cycle after the first word handshake. With data available every cycle, ccff_shift_en is high for exactly CHAIN_LEN contiguous cycles and done follows one cycle after the last bit.
- abort (any non-IDLE state): next cycle go to IDLE. Buffers flushed, ccff_shift_en=0, busy=0, no done pulse, underrun retained. abort wins over a simultaneous handshake: the word is not accepted.
- start while busy is ignored. start and abort together in IDLE: start is ignored.
- Bit-counter arithmetic saturates at CHAIN_LEN; it never wraps.

Optional Feature:
- Macro CCFF_READBACK_EN.
- Defined:
  - Adds output readback_crc[15:0].
  - CRC-16-CCITT (polynomial 0x1021, init 0xFFFF, MSB-first, no reflection, no final xor) is updated with ccff_tail on every cycle ccff_shift_en=1.
  - CRC is re-initialised on accepted start and frozen from DONE until the next start, so it signatures the previous chain contents.
  - Reset value 0xFFFF.
- Undefined: no port, no CRC logic; all other behaviour is identical.

Test Plan:
- Basic load, WORD_W=8, CHAIN_LEN=20, words 0xA5,0x3C,0xF0 back-to-back -> ccff_head sequence 1010_0101_0011_1100_1111; ccff_shift_en high 20 contiguous cycles; done pulses 1 cycle later; low nibble of 0xF0 never shifted; underrun=0.
- Starvation: withhold the 2nd word for 3 cycles -> ccff_shift_en low exactly 3 cycles after bit 8; total shift-enabled cycles = 20; underrun=1 after done; bit sequence unchanged.
- Abort after 5 shifted bits -> next cycle busy=0, ccff_shift_en=0, word_ready=0; no done pulse; a subsequent start reloads all 20 bits correctly.
- Async reset asserted mid-SHIFT, between clock edges -> all outputs 0 immediately; after release, start runs a clean full load.
- start pulsed while busy, and word_valid in IDLE -> no effect; no word accepted; sequence identical to the basic test.
- With CCFF_READBACK_EN: load pattern A, then load B -> readback_crc after the 2nd load equals the bit-serial CRC-16-CCITT model of pattern A's 20 bits (ccff_tail modelled as a 20-flop chain).

Source files
------------

// File: rtl/ccff_chain_loader_if.sv
// ccff_chain_loader_if
//   Word handshake between a bitstream source and the chain loader.
//   Parameter: WORD_W  - bitstream word width.
//   Signals:   word_data  - bitstream word
//              word_valid - word_data is valid
//              word_ready - loader accepts word_data this cycle
//   Modports:  master (bitstream source), slave (chain loader)
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_data, output word_valid, input word_ready);
  modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
//   Bit-serial driver for a logic tile's configuration chain. Accepts
//   bitstream words, serialises them MSB-first onto ccff_head and asserts
//   ccff_shift_en for exactly CHAIN_LEN bits, then pulses done.
//   Optional macro CCFF_READBACK_EN adds readback_crc, a CRC-16-CCITT
//   signature of the bits returning on ccff_tail.
// Ports:
//   prog_clk, prog_reset   - clock, async active-low reset
//   start, abort           - begin a load / cancel an in-progress load
//   word_if (slave)        - word_data / word_valid / word_ready handshake
//   ccff_head, ccff_shift_en, ccff_tail - chain serial in, enable, serial out
//   busy, done, underrun   - status (underrun is sticky per load)
//   readback_crc[15:0]     - only with CCFF_READBACK_EN
module ccff_chain_loader #(
  parameter int  WORD_W    = 8,
  parameter int  CHAIN_LEN = 20,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic               prog_clk,
  input  logic               prog_reset,
  input  logic               start,
  input  logic               abort,
  ccff_chain_loader_if.slave word_if,
  output logic               ccff_head,
  output logic               ccff_shift_en,
  input  logic               ccff_tail,
  output logic               busy,
  output logic               done,
  output logic               underrun
`ifdef CCFF_READBACK_EN
  ,
  output logic [15:0]        readback_crc
`endif
);

  localparam int SC_W = $clog2(WORD_W + 1);
  localparam logic [SC_W-1:0]  SC_ZERO  = SC_W'(0);
  localparam logic [SC_W-1:0]  SC_ONE   = SC_W'(1);
  localparam logic [SC_W-1:0]  SC_FULL  = SC_W'(WORD_W);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CHAIN_LEN);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [WORD_W-1:0] sr_r, sr_s, hr_r, hr_s;
  logic [SC_W-1:0]   sr_cnt_r, sr_cnt_s;
  logic              hr_full_r, hr_full_s;
  logic [CNT_W-1:0]  bit_cnt_r, bit_cnt_s;
  logic              head_r, head_s, en_r, en_s;
  logic              busy_r, busy_s, done_r, done_s;
  logic              underrun_r, underrun_s;
  logic              word_ready_s, accept_s, sr_empty_s, chain_full_s;
  logic              shift_s, sr_drain_s, start_acc_s;

  assign word_ready_s       = busy_r & ~hr_full_r & ~abort;
  assign word_if.word_ready = word_ready_s;
  assign accept_s           = word_if.word_valid & word_ready_s;
  assign sr_empty_s         = (sr_cnt_r == SC_ZERO);
  assign chain_full_s       = (bit_cnt_r == CNT_MAX);
  assign start_acc_s        = (state_r == ST_IDLE) & start & ~abort;
  // A bit leaves SR only while the chain still needs bits; abort suppresses it.
  assign shift_s            = (state_r == ST_SHIFT) & ~sr_empty_s & ~chain_full_s & ~abort;
  // SR is free for a new word if already empty or its last bit goes out now.
  assign sr_drain_s         = sr_empty_s | (shift_s & (sr_cnt_r == SC_ONE));

  // State register.
  always_ff @(posedge prog_clk or negedge prog_reset) begin
    if (!prog_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_acc_s) state_s = ST_LOAD;
        else             state_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (abort)                      state_s = ST_IDLE;
        else if (~sr_empty_s | accept_s) state_s = ST_SHIFT;
        else                            state_s = ST_LOAD;
      end
      ST_SHIFT: begin
        if (abort)             state_s = ST_IDLE;
        else if (chain_full_s) state_s = ST_DONE;
        else                   state_s = ST_SHIFT;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Output and datapath next values; all outputs leave through registers.
  always_comb begin
    head_s     = head_r;
    en_s       = 1'b0;
    busy_s     = (state_s == ST_LOAD) | (state_s == ST_SHIFT);
    done_s     = (state_s == ST_DONE);
    underrun_s = underrun_r;
    bit_cnt_s  = bit_cnt_r;
    sr_s       = sr_r;
    sr_cnt_s   = sr_cnt_r;
    hr_s       = hr_r;
    hr_full_s  = hr_full_r;

    if (start_acc_s) begin
      bit_cnt_s  = CNT_ZERO;
      underrun_s = 1'b0;
    end else if (shift_s) begin
      head_s    = sr_r[WORD_W-1];
      en_s      = 1'b1;
      bit_cnt_s = bit_cnt_r + CNT_ONE;
    end else if ((state_r == ST_SHIFT) && sr_empty_s && !chain_full_s) begin
      underrun_s = 1'b1;
    end else begin
      underrun_s = underrun_r;
    end

    // Leaving the active states discards whatever is still buffered.
    if ((state_s == ST_IDLE) || (state_s == ST_DONE)) begin
      sr_s      = {WORD_W{1'b0}};
      sr_cnt_s  = SC_ZERO;
      hr_s      = {WORD_W{1'b0}};
      hr_full_s = 1'b0;
    end else begin
      if (shift_s) begin
        sr_s     = {sr_r[WORD_W-2:0], 1'b0};
        sr_cnt_s = sr_cnt_r - SC_ONE;
      end else begin
        sr_s     = sr_r;
        sr_cnt_s = sr_cnt_r;
      end
      if (sr_drain_s && hr_full_r) begin
        sr_s      = hr_r;
        sr_cnt_s  = SC_FULL;
        hr_full_s = 1'b0;
      end else if (accept_s && sr_drain_s) begin
        sr_s     = word_if.word_data;
        sr_cnt_s = SC_FULL;
      end else if (accept_s) begin
        hr_s      = word_if.word_data;
        hr_full_s = 1'b1;
      end else begin
        hr_full_s = hr_full_r;
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge prog_clk or negedge prog_reset) begin
    if (!prog_reset) begin
      head_r     <= 1'b0;
      en_r       <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      underrun_r <= 1'b0;
      bit_cnt_r  <= CNT_ZERO;
      sr_r       <= {WORD_W{1'b0}};
      sr_cnt_r   <= SC_ZERO;
      hr_r       <= {WORD_W{1'b0}};
      hr_full_r  <= 1'b0;
    end else begin
      head_r     <= head_s;
      en_r       <= en_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      underrun_r <= underrun_s;
      bit_cnt_r  <= bit_cnt_s;
      sr_r       <= sr_s;
      sr_cnt_r   <= sr_cnt_s;
      hr_r       <= hr_s;
      hr_full_r  <= hr_full_s;
    end
  end

  assign ccff_head     = head_r;
  assign ccff_shift_en = en_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign underrun      = underrun_r;

`ifdef CCFF_READBACK_EN
  // One MSB-first CRC-16-CCITT step (poly 0x1021).
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  logic [15:0] crc_r;

  // Signature of bits leaving the chain tail; frozen outside shift cycles.
  always_ff @(posedge prog_clk or negedge prog_reset) begin
    if (!prog_reset) begin
      crc_r <= 16'hFFFF;
    end else if (start_acc_s) begin
      crc_r <= 16'hFFFF;
    end else if (en_r) begin
      crc_r <= crc16_step(crc_r, ccff_tail);
    end else begin
      crc_r <= crc_r;
    end
  end

  assign readback_crc = crc_r;
`else
  logic unused_tail_s;
  assign unused_tail_s = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader (WORD_W=8, CHAIN_LEN=20).
// The downstream configuration chain is modelled as a 20-flop shift register.
module tb_ccff_chain_loader;

  logic prog_clk = 1'b0;
  logic prog_reset = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic ccff_head, ccff_shift_en, ccff_tail, busy, done, underrun;
  logic [19:0] chain_r = 20'h00000;
`ifdef CCFF_READBACK_EN
  logic [15:0] readback_crc;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Per-load observations
  logic [19:0] seq_v;
  int en_cnt_v, gap_v, done_cnt_v;
  logic done_prev_en_v;
  logic [19:0] seq_a;

  ccff_chain_loader_if #(.WORD_W(8)) wif ();

  ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(20)) dut (
    .prog_clk      (prog_clk),
    .prog_reset    (prog_reset),
    .start         (start),
    .abort         (abort),
    .word_if       (wif),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done),
    .underrun      (underrun)
`ifdef CCFF_READBACK_EN
    ,
    .readback_crc  (readback_crc)
`endif
  );

  always #5 prog_clk = ~prog_clk;

  // Downstream chain model: advances only when shift enable is high.
  always @(posedge prog_clk) begin
    if (ccff_shift_en) chain_r <= {chain_r[18:0], ccff_head};
  end
  assign ccff_tail = chain_r[19];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_model(input logic [19:0] bits);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int i = 19; i >= 0; i--) begin
      fb = c[15] ^ bits[i];
      c = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  // One load: start, offer three words, observe at negedges.
  //   hold_cyc   : cycles word 2 is withheld after word 1 transfers
  //   abort_bits : abort once this many bits have shifted (0 = never)
  //   reset_bits : async reset once this many bits have shifted (0 = never)
  //   extra_bits : pulse start again at this bit (0 = never)
  task automatic do_load(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                         input int hold_cyc, input int abort_bits, input int reset_bits,
                         input int extra_bits);
    logic [7:0] wl [3];
    int widx, hold, post;
    logic fin, prev_en, rdy;
    wl[0] = w0; wl[1] = w1; wl[2] = w2;
    widx = 0; hold = hold_cyc; post = 0; fin = 1'b0; prev_en = 1'b0;
    seq_v = 20'h00000; en_cnt_v = 0; gap_v = 0; done_cnt_v = 0; done_prev_en_v = 1'b0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      @(negedge prog_clk);
      start = (cyc == 0);
      if (ccff_shift_en) begin
        seq_v = {seq_v[18:0], ccff_head};
        en_cnt_v++;
      end else if (busy && en_cnt_v > 0 && en_cnt_v < 20) begin
        gap_v++;
      end
      if (done) begin
        done_cnt_v++;
        done_prev_en_v = prev_en;
      end
      prev_en = ccff_shift_en;
      if (extra_bits > 0 && ccff_shift_en && en_cnt_v == extra_bits) start = 1'b1;
      rdy = wif.word_ready;
      if (abort_bits > 0 && ccff_shift_en && en_cnt_v == abort_bits) begin
        abort = 1'b1;
        wif.word_valid = 1'b0;
        @(negedge prog_clk);
        abort = 1'b0;
        check_val("abort_busy", busy, 1'b0);
        check_val("abort_shift_en", ccff_shift_en, 1'b0);
        check_val("abort_ready", wif.word_ready, 1'b0);
        repeat (5) begin
          @(negedge prog_clk);
          if (done) done_cnt_v++;
        end
        check_val("abort_no_done", done_cnt_v, 0);
        fin = 1'b1;
      end else if (reset_bits > 0 && ccff_shift_en && en_cnt_v == reset_bits) begin
        #2 prog_reset = 1'b0;
        #1;
        check_val("arst_head", ccff_head, 1'b0);
        check_val("arst_shift_en", ccff_shift_en, 1'b0);
        check_val("arst_busy", busy, 1'b0);
        check_val("arst_done", done, 1'b0);
        check_val("arst_underrun", underrun, 1'b0);
        check_val("arst_ready", wif.word_ready, 1'b0);
        wif.word_valid = 1'b0;
        @(negedge prog_clk);
        prog_reset = 1'b1;
        fin = 1'b1;
      end else begin
        if (widx < 3) begin
          if (widx == 1 && hold > 0) begin
            wif.word_valid = 1'b0;
            hold--;
          end else begin
            wif.word_data  = wl[widx];
            wif.word_valid = 1'b1;
            if (rdy) widx++;
          end
        end else begin
          wif.word_valid = 1'b0;
        end
        if (post > 0) begin
          post--;
          if (post == 0) fin = 1'b1;
        end else if (done_cnt_v > 0) begin
          post = 2;
        end
      end
    end
    start = 1'b0;
    abort = 1'b0;
    wif.word_valid = 1'b0;
    if (!fin) check_val("load_timeout", 0, 1);
  endtask

  task automatic check_full_load(input string tag, input logic [19:0] exp_seq,
                                 input int exp_gap, input logic exp_underrun);
    check_val({tag, "_seq"}, seq_v, exp_seq);
    check_val({tag, "_en_cycles"}, en_cnt_v, 20);
    check_val({tag, "_stall_cycles"}, gap_v, exp_gap);
    check_val({tag, "_done_pulses"}, done_cnt_v, 1);
    check_val({tag, "_done_after_last"}, done_prev_en_v, 1'b1);
    check_val({tag, "_underrun"}, underrun, exp_underrun);
    check_val({tag, "_busy_end"}, busy, 1'b0);
  endtask

  initial begin
    wif.word_valid = 1'b0;
    wif.word_data  = 8'h00;
    #12;
    check_val("rst_head", ccff_head, 1'b0);
    check_val("rst_shift_en", ccff_shift_en, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_underrun", underrun, 1'b0);
    check_val("rst_ready", wif.word_ready, 1'b0);
`ifdef CCFF_READBACK_EN
    check_val("rst_crc", readback_crc, 16'hFFFF);
`endif
    @(negedge prog_clk);
    prog_reset = 1'b1;
    @(negedge prog_clk);

    // Basic back-to-back load
    do_load(8'hA5, 8'h3C, 8'hF0, 0, 0, 0, 0);
    check_full_load("basic", 20'hA53CF, 0, 1'b0);

    // Word 2 withheld: three stall cycles after bit 8
    do_load(8'hA5, 8'h3C, 8'hF0, 10, 0, 0, 0);
    check_full_load("starve", 20'hA53CF, 3, 1'b1);

    // Abort after 5 bits, then a clean reload
    do_load(8'hA5, 8'h3C, 8'hF0, 0, 5, 0, 0);
    check_val("abort_bits_seen", en_cnt_v, 5);
    check_val("abort_underrun_kept", underrun, 1'b0);
    do_load(8'hA5, 8'h3C, 8'hF0, 0, 0, 0, 0);
    check_full_load("post_abort", 20'hA53CF, 0, 1'b0);

    // Async reset mid-shift, then a clean reload
    do_load(8'hA5, 8'h3C, 8'hF0, 0, 0, 6, 0);
    do_load(8'hA5, 8'h3C, 8'hF0, 0, 0, 0, 0);
    check_full_load("post_arst", 20'hA53CF, 0, 1'b0);

    // Words offered in IDLE are ignored; a start while busy is ignored
    @(negedge prog_clk);
    wif.word_data  = 8'h77;
    wif.word_valid = 1'b1;
    repeat (3) @(negedge prog_clk);
    check_val("idle_ready", wif.word_ready, 1'b0);
    check_val("idle_busy", busy, 1'b0);
    wif.word_valid = 1'b0;
    do_load(8'hA5, 8'h3C, 8'hF0, 0, 0, 0, 3);
    check_full_load("restart", 20'hA53CF, 0, 1'b0);

    // Pattern A then pattern B; the tail signature covers A
    seq_a = seq_v;
    do_load(8'h5A, 8'hC3, 8'h0F, 0, 0, 0, 0);
    check_full_load("pattern_b", 20'h5AC30, 0, 1'b0);
`ifdef CCFF_READBACK_EN
    check_val("readback_crc", readback_crc, crc_model(seq_a));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

endmodule
